// File: rtl/if_stage_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, fetch
// constants and the word-alignment helper.
package if_stage_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_KILL  = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] adrs);
    return {adrs[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_fetch_pc_reg.sv
// Program-counter register with asynchronous reset and load enable.
module if_stage_fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en_i,
  input  logic [31:0] load_val_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_en_i) begin
      pc_q <= load_val_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, requests instruction memory, absorbs
// stalls in a one-word hold buffer and loads the IF/ID pipeline register.
module if_stage_fetch
  import if_stage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_adrs,
  output logic [31:0] imem_adrs,
  output logic        imem_req,
  input  logic [31:0] imem_inst,
  input  logic        imem_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifinst_q, ifinst_d;
  logic        ifvalid_q, ifvalid_d;
  logic        pc_ld;
  logic [31:0] pc_nxt;
  logic [31:0] pc;
  logic [31:0] target;

  if_stage_fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load_en_i  (pc_ld),
    .load_val_i (pc_nxt),
    .pc_o       (pc)
  );

  assign target = align_word(branch_adrs);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    redirect_d = redirect_q;
    ifpc_d     = ifpc_q;
    ifinst_d   = ifinst_q;
    ifvalid_d  = ifvalid_q;
    pc_ld      = 1'b0;
    pc_nxt     = pc + STEP;
    imem_req   = ~rst && (state_q != ST_HOLD);

    if (branch_taken) begin
      ifpc_d    = 32'h0;
      ifinst_d  = NOP_INST;
      ifvalid_d = 1'b0;
      hold_d    = NOP_INST;
      // An unfinished access keeps the old address on the bus; the target
      // waits in redirect_q until the memory lets go.
      if ((state_q != ST_HOLD) && !imem_ready) begin
        redirect_d = target;
        state_d    = ST_KILL;
      end else begin
        pc_ld   = 1'b1;
        pc_nxt  = target;
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            if (freeze) begin
              hold_d  = imem_inst;
              state_d = ST_HOLD;
            end else begin
              ifpc_d    = pc + STEP;
              ifinst_d  = imem_inst;
              ifvalid_d = 1'b1;
              pc_ld     = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!freeze) begin
            ifpc_d    = pc + STEP;
            ifinst_d  = hold_q;
            ifvalid_d = 1'b1;
            pc_ld     = 1'b1;
            state_d   = ST_FETCH;
          end
        end
        ST_KILL: begin
          if (imem_ready) begin
            pc_ld   = 1'b1;
            pc_nxt  = redirect_q;
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      hold_q     <= NOP_INST;
      redirect_q <= RESET_PC;
      ifpc_q     <= 32'h0;
      ifinst_q   <= NOP_INST;
      ifvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      redirect_q <= redirect_d;
      ifpc_q     <= ifpc_d;
      ifinst_q   <= ifinst_d;
      ifvalid_q  <= ifvalid_d;
    end
  end

  assign imem_adrs = pc;
  assign if_pc     = ifpc_q;
  assign if_inst   = ifinst_q;
  assign if_valid  = ifvalid_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed scenarios then random traffic, all
// checked against a transaction-level model of the fetch rules.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_adrs;
  logic [31:0] imem_adrs;
  logic        imem_req;
  logic [31:0] imem_inst;
  logic        imem_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int checks   = 0;
  int failures = 0;

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifinst;
  logic        m_ifvalid;
  logic        m_kill;
  logic [31:0] m_pending;
  logic [31:0] m_held[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0000;
      32'h4:   return 32'h8001_060A;
      32'h8:   return 32'h0401_1000;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign imem_inst = mem_f(imem_adrs);

  if_stage_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_adrs  (branch_adrs),
    .imem_adrs    (imem_adrs),
    .imem_req     (imem_req),
    .imem_inst    (imem_inst),
    .imem_ready   (imem_ready),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_ifpc    = 32'h0;
    m_ifinst  = 32'h0;
    m_ifvalid = 1'b0;
    m_kill    = 1'b0;
    m_pending = 32'h0;
    m_held.delete();
  endtask

  function automatic logic model_req();
    return !rst && (m_held.size() == 0);
  endfunction

  // Applies the fetch rules for the cycle about to end, using current inputs.
  task automatic model_step();
    logic req;
    logic [31:0] tgt;
    if (rst) begin
      model_reset();
      return;
    end
    req = model_req();
    tgt = branch_adrs & 32'hFFFF_FFFC;
    if (branch_taken) begin
      m_ifpc = 0; m_ifinst = 0; m_ifvalid = 0;
      m_held.delete();
      if (req && !imem_ready) begin
        m_kill = 1; m_pending = tgt;
      end else begin
        m_kill = 0; m_pc = tgt;
      end
    end else if (m_kill) begin
      if (imem_ready) begin
        m_kill = 0; m_pc = m_pending;
      end
    end else if (m_held.size() > 0) begin
      if (!freeze) begin
        m_ifinst = m_held.pop_front();
        m_ifpc = m_pc + 4; m_ifvalid = 1; m_pc = m_pc + 4;
      end
    end else if (imem_ready) begin
      if (freeze) m_held.push_back(mem_f(m_pc));
      else begin
        m_ifinst = mem_f(m_pc);
        m_ifpc = m_pc + 4; m_ifvalid = 1; m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".adrs"},  imem_adrs, m_pc);
    chk({tag, ".req"},   {31'b0, imem_req}, {31'b0, model_req()});
    chk({tag, ".ifpc"},  if_pc, m_ifpc);
    chk({tag, ".inst"},  if_inst, m_ifinst);
    chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, m_ifvalid});
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic drive(input logic rdy, input logic frz, input logic br, input logic [31:0] ba);
    imem_ready = rdy; freeze = frz; branch_taken = br; branch_adrs = ba;
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 0, 0, 0);
    model_reset();
    #2;
    chk("rst.req", {31'b0, imem_req}, 32'h0);
    chk("rst.valid", {31'b0, if_valid}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t1.adrs0", imem_adrs, 32'h0);

    // 1: sequential fetch with combinational memory
    step("t1a");
    chk("t1.pc4", if_pc, 32'h4);
    chk("t1.inst0", if_inst, 32'h0);
    chk("t1.adrs4", imem_adrs, 32'h4);
    step("t1b");
    chk("t1.pc8", if_pc, 32'h8);
    chk("t1.inst4", if_inst, 32'h8001_060A);
    chk("t1.adrs8", imem_adrs, 32'h8);

    // 2: freeze for three cycles at pc=8
    drive(1, 1, 0, 0);
    step("t2a");
    chk("t2.req_hold", {31'b0, imem_req}, 32'h0);
    step("t2b");
    step("t2c");
    chk("t2.inst_stable", if_inst, 32'h8001_060A);
    drive(1, 0, 0, 0);
    step("t2d");
    chk("t2.inst8", if_inst, 32'h0401_1000);
    chk("t2.pc12", if_pc, 32'hC);
    chk("t2.adrs12", imem_adrs, 32'hC);

    // 3: taken branch in FETCH
    drive(1, 0, 1, 32'h40);
    step("t3a");
    chk("t3.adrs", imem_adrs, 32'h40);
    chk("t3.valid0", {31'b0, if_valid}, 32'h0);
    drive(1, 0, 0, 0);
    step("t3b");
    chk("t3.inst", if_inst, mem_f(32'h40));
    chk("t3.pc", if_pc, 32'h44);

    // 4: slow memory, branch while access outstanding
    drive(0, 0, 0, 0);
    step("t4a");
    drive(0, 0, 1, 32'h20);
    step("t4b");
    chk("t4.adrs_held", imem_adrs, 32'h44);
    drive(0, 0, 0, 0);
    step("t4c");
    chk("t4.adrs_held2", imem_adrs, 32'h44);
    drive(1, 0, 0, 0);
    step("t4d");
    chk("t4.discard", {31'b0, if_valid}, 32'h0);
    chk("t4.adrs20", imem_adrs, 32'h20);
    step("t4e");
    chk("t4.inst20", if_inst, mem_f(32'h20));

    // 5: misaligned target
    drive(1, 0, 1, 32'h43);
    step("t5");
    chk("t5.align", imem_adrs, 32'h40);

    // 6: reset while waiting on memory
    drive(1, 0, 0, 0);
    step("t6a");
    drive(0, 0, 0, 0);
    step("t6b");
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6.async_adrs", imem_adrs, 32'h0);
    chk("t6.async_req", {31'b0, imem_req}, 32'h0);
    chk("t6.async_valid", {31'b0, if_valid}, 32'h0);
    chk("t6.async_pc", if_pc, 32'h0);
    imem_ready = 1'b1;
    step("t6c");
    rst = 1'b0;
    chk("t6.first_adrs", imem_adrs, 32'h0);
    step("t6d");
    chk("t6.first_pc", if_pc, 32'h4);

    // 7: branch and freeze together, in FETCH and in HOLD
    drive(1, 1, 1, 32'h80);
    step("t7a");
    chk("t7.adrs", imem_adrs, 32'h80);
    chk("t7.valid", {31'b0, if_valid}, 32'h0);
    drive(1, 1, 0, 0);
    step("t7b");
    drive(1, 1, 1, 32'hC0);
    step("t7c");
    chk("t7.hold_flush", imem_adrs, 32'hC0);
    drive(1, 0, 0, 0);
    step("t7d");
    chk("t7.inst", if_inst, mem_f(32'hC0));

    // PC wrap
    drive(1, 0, 1, 32'hFFFF_FFFC);
    step("wrap_a");
    drive(1, 0, 0, 0);
    step("wrap_b");
    chk("wrap.pc", if_pc, 32'h0);
    chk("wrap.adrs", imem_adrs, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
